// File: rtl/demux_pkg.sv
// demux_pkg: shared sizes, lane index type and FSM state type for the
// demux register bank (demux_reg_bank / demux_lane_reg).
package demux_pkg;

  localparam int DEMUX_I_WIDTH   = 8;
  localparam int DEMUX_F_WIDTH   = 8;
  localparam int DW              = DEMUX_I_WIDTH + DEMUX_F_WIDTH;
  localparam int DEMUX_SEL_WIDTH = 3;
  localparam int DEMUX_N_LANES   = 8;

  typedef logic [DEMUX_SEL_WIDTH-1:0] lane_idx_t;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    FULL = 2'd1
  } demux_state_t;

endpackage

// File: rtl/demux_lane_reg.sv
// demux_lane_reg: one lane of the bank -- a sample register plus its
// "loaded" flag. A load always wins over a clear, so a write landing in the
// same cycle as a release keeps its lane marked valid.
module demux_lane_reg
  import demux_pkg::*;
#(
  parameter int DATA_W = DW
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     load_i,
  input  logic                     clr_i,
  input  logic signed [DATA_W-1:0] data_i,
  output logic signed [DATA_W-1:0] data_o,
  output logic                     valid_o
);

  logic signed [DATA_W-1:0] data_q;
  logic                     valid_q;

  // Lane storage: reset to zero, load copies the sample, clear only drops the flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      data_q  <= data_i;
      valid_q <= 1'b1;
    end else if (clr_i) begin
      data_q  <= data_q;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_q;
      valid_q <= valid_q;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/demux_reg_bank.sv
// demux_reg_bank: scatters one signed fixed-point stream into a bank of
// NUMBER_OUTPUT_DEMUX lane registers and presents the bank in parallel once
// every lane is loaded, holding it until release_i.
// Build option: define DEMUX_AUTO_SEL_EN to ignore sel_demux_i and pick the
// lane from an internal round-robin counter instead.
module demux_reg_bank
  import demux_pkg::*;
#(
  parameter int I_WIDTH             = DEMUX_I_WIDTH,
  parameter int F_WIDTH             = DEMUX_F_WIDTH,
  parameter int SEL_WIDTH_DEMUX     = DEMUX_SEL_WIDTH,
  parameter int NUMBER_OUTPUT_DEMUX = DEMUX_N_LANES
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic signed [I_WIDTH+F_WIDTH-1:0] data_in_i,
  input  logic [SEL_WIDTH_DEMUX-1:0]        sel_demux_i,
  input  logic                              valid_i,
  output logic                              ready_o,
  output logic signed [I_WIDTH+F_WIDTH-1:0] data_out_o [0:NUMBER_OUTPUT_DEMUX-1],
  output logic [NUMBER_OUTPUT_DEMUX-1:0]    lane_valid_o,
  output logic                              full_o,
  input  logic                              release_i,
  output logic                              sel_err_o
);

  localparam int DATA_W = I_WIDTH + F_WIDTH;
  localparam int N      = NUMBER_OUTPUT_DEMUX;
  localparam int NSLOT  = 1 << SEL_WIDTH_DEMUX;

  demux_state_t               state_q, state_d;
  logic                       full_q, full_d;
  logic                       sel_err_q, sel_err_d;
  logic [SEL_WIDTH_DEMUX-1:0] lane_sel_s;
  logic                       in_range_s;
  logic                       ready_s;
  logic                       accept_s;
  logic                       wr_en_s;
  logic                       all_set_s;
  logic [NSLOT-1:0]           valid_pad_s;
  logic [N-1:0]               lane_valid_s;
  logic [N-1:0]               load_s;
  logic [N-1:0]               next_mask_s;

`ifdef DEMUX_AUTO_SEL_EN
  localparam logic [SEL_WIDTH_DEMUX-1:0] LAST_LANE = SEL_WIDTH_DEMUX'(N - 1);
  localparam logic [SEL_WIDTH_DEMUX-1:0] ONE_LANE  = SEL_WIDTH_DEMUX'(1);

  logic [SEL_WIDTH_DEMUX-1:0] cnt_q, cnt_d;

  // Counter lane select: every lane index is always in range.
  always_comb begin
    lane_sel_s = cnt_q;
    in_range_s = 1'b1;
  end

  // Round-robin pointer; a release restarts at lane 0 unless a write lands in
  // that same cycle, in which case the pointer moves past the lane just written
  // so it can never be overwritten before the bank completes.
  always_comb begin
    cnt_d = cnt_q;
    if (accept_s) begin
      if (cnt_q == LAST_LANE) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + ONE_LANE;
      end
    end else if (release_i) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Lane pointer register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  // External lane select; indices at or above N are accepted but dropped.
  always_comb begin
    lane_sel_s = sel_demux_i;
    if (int'(sel_demux_i) < N) begin
      in_range_s = 1'b1;
    end else begin
      in_range_s = 1'b0;
    end
  end
`endif

  // Ready: only in FILL, and only if the addressed lane is still empty;
  // out-of-range selects are always taken so they can be flagged and dropped.
  always_comb begin
    valid_pad_s        = '0;
    valid_pad_s[N-1:0] = lane_valid_s;
    if (state_q != FILL) begin
      ready_s = 1'b0;
    end else if (!in_range_s) begin
      ready_s = 1'b1;
    end else begin
      ready_s = ~valid_pad_s[lane_sel_s];
    end
  end

  // Transfer decode: per-lane load strobes and the mask the bank will hold next cycle.
  always_comb begin
    accept_s = valid_i & ready_s;
    wr_en_s  = accept_s & in_range_s;
    load_s   = '0;
    for (int k = 0; k < N; k++) begin
      load_s[k] = wr_en_s && (int'(lane_sel_s) == k);
    end
    if (release_i) begin
      next_mask_s = load_s;
    end else begin
      next_mask_s = lane_valid_s | load_s;
    end
    all_set_s = &next_mask_s;
  end

  // FSM: FILL until the last empty lane is written, FULL until released.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL: begin
        if (all_set_s) begin
          state_d = FULL;
        end else begin
          state_d = FILL;
        end
      end
      FULL: begin
        if (release_i) begin
          state_d = FILL;
        end else begin
          state_d = FULL;
        end
      end
      default: state_d = FILL;
    endcase
    full_d = (state_d == FULL);
`ifdef DEMUX_AUTO_SEL_EN
    sel_err_d = 1'b0;
`else
    sel_err_d = accept_s & ~in_range_s;
`endif
  end

  // Control registers: state, full flag and the one-cycle select-error pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= FILL;
      full_q    <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      full_q    <= full_d;
      sel_err_q <= sel_err_d;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_lane
    demux_lane_reg #(
      .DATA_W(DATA_W)
    ) u_lane (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .load_i (load_s[g]),
      .clr_i  (release_i),
      .data_i (data_in_i),
      .data_o (data_out_o[g]),
      .valid_o(lane_valid_s[g])
    );
  end

  assign ready_o      = ready_s;
  assign lane_valid_o = lane_valid_s;
  assign full_o       = full_q;
  assign sel_err_o    = sel_err_q;

endmodule

// File: tb/tb_demux_reg_bank.sv
// tb_demux_reg_bank: directed vectors against an 8-lane and a 6-lane bank.
module tb_demux_reg_bank;
  import demux_pkg::*;

  logic clk = 1'b0;
  logic rst;

  logic signed [15:0] din8, din6;
  logic [2:0]         sel8, sel6;
  logic               vld8, vld6, rel8, rel6;
  logic               rdy8, rdy6, full8, full6, err8, err6;
  logic signed [15:0] dout8 [0:7];
  logic signed [15:0] dout6 [0:5];
  logic [7:0]         lv8;
  logic [5:0]         lv6;
  logic [7:0]         m8;
  logic [5:0]         m6;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  demux_reg_bank #(
    .I_WIDTH(8), .F_WIDTH(8), .SEL_WIDTH_DEMUX(3), .NUMBER_OUTPUT_DEMUX(8)
  ) u_dut8 (
    .clk_i(clk), .rst_i(rst), .data_in_i(din8), .sel_demux_i(sel8),
    .valid_i(vld8), .ready_o(rdy8), .data_out_o(dout8), .lane_valid_o(lv8),
    .full_o(full8), .release_i(rel8), .sel_err_o(err8)
  );

  demux_reg_bank #(
    .I_WIDTH(8), .F_WIDTH(8), .SEL_WIDTH_DEMUX(3), .NUMBER_OUTPUT_DEMUX(6)
  ) u_dut6 (
    .clk_i(clk), .rst_i(rst), .data_in_i(din6), .sel_demux_i(sel6),
    .valid_i(vld6), .ready_o(rdy6), .data_out_o(dout6), .lane_valid_o(lv6),
    .full_o(full6), .release_i(rel6), .sel_err_o(err6)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    // Reset with junk on every input.
    rst  = 1'b1;
    din8 = 16'hdead; sel8 = 3'd5; vld8 = 1'b1; rel8 = 1'b1;
    din6 = 16'hbeef; sel6 = 3'd2; vld6 = 1'b1; rel6 = 1'b1;
    tick();
    tick();
    rst  = 1'b0;
    vld8 = 1'b0; rel8 = 1'b0; sel8 = 3'd0;
    vld6 = 1'b0; rel6 = 1'b0; sel6 = 3'd0;
    settle();
    check("rst_lv8", lv8, 32'h0);
    check("rst_full8", full8, 32'h0);
    check("rst_err8", err8, 32'h0);
    check("rst_rdy8", rdy8, 32'h1);
    check("rst_lv6", lv6, 32'h0);
    for (int k = 0; k < 8; k++) check("rst_data8", dout8[k], 32'h0);

`ifdef DEMUX_AUTO_SEL_EN
    // Six writes fill lanes 0..5 in order regardless of sel.
    for (int i = 0; i < 6; i++) begin
      sel6 = 3'd7; din6 = 16'((i + 1) << 8); vld6 = 1'b1;
      settle();
      check("auto_rdy6", rdy6, 32'h1);
      tick();
    end
    vld6 = 1'b0;
    settle();
    check("auto_full6", full6, 32'h1);
    check("auto_lv6", lv6, 32'h3f);
    check("auto_rdy_full6", rdy6, 32'h0);
    check("auto_err6", err6, 32'h0);
    for (int k = 0; k < 6; k++) check("auto_data6", dout6[k], 32'((k + 1) << 8));
    rel6 = 1'b1;
    tick();
    rel6 = 1'b0;
    settle();
    check("auto_rel_full6", full6, 32'h0);
    check("auto_rel_lv6", lv6, 32'h0);
    din6 = 16'h0707; vld6 = 1'b1;
    tick();
    vld6 = 1'b0;
    settle();
    check("auto_w7_lv6", lv6, 32'h01);
    check("auto_w7_data6", dout6[0], 32'h0707);
    check("auto_w7_err6", err6, 32'h0);
`else
    // Fill all eight lanes in reverse order.
    m8 = 8'h00;
    for (int i = 0; i < 8; i++) begin
      sel8 = 3'(7 - i); din8 = 16'((i + 1) << 8); vld8 = 1'b1;
      settle();
      check("fill_rdy8", rdy8, 32'h1);
      tick();
      vld8 = 1'b0;
      m8[7 - i] = 1'b1;
      settle();
      check("fill_full8", full8, 32'(i == 7));
      check("fill_lv8", lv8, 32'(m8));
    end
    sel8 = 3'd0;
    settle();
    check("full_rdy8", rdy8, 32'h0);
    for (int k = 0; k < 8; k++) check("fill_data8", dout8[k], 32'((8 - k) << 8));

    // Release in FULL with a write offered: the write is not taken.
    sel8 = 3'd0; din8 = 16'h7777; vld8 = 1'b1; rel8 = 1'b1;
    settle();
    check("rel_rdy8", rdy8, 32'h0);
    tick();
    rel8 = 1'b0; vld8 = 1'b0;
    settle();
    check("rel_full8", full8, 32'h0);
    check("rel_lv8", lv8, 32'h0);
    check("rel_rdy_after8", rdy8, 32'h1);
    check("rel_stale8", dout8[0], 32'h0800);

    // Duplicate write to lane 3 stalls and keeps the first value.
    sel8 = 3'd3; din8 = 16'sh8765; vld8 = 1'b1;
    settle();
    check("dup_rdy1_8", rdy8, 32'h1);
    tick();
    din8 = 16'h5678;
    settle();
    check("dup_rdy2_8", rdy8, 32'h0);
    tick();
    vld8 = 1'b0;
    settle();
    check("dup_data8", dout8[3], 32'hffff8765);
    check("dup_lv8", lv8, 32'h08);

    // Release in FILL with a same-cycle write: only the written lane stays valid.
    sel8 = 3'd5; din8 = 16'h0a0a; vld8 = 1'b1; rel8 = 1'b1;
    settle();
    check("relw_rdy8", rdy8, 32'h1);
    tick();
    vld8 = 1'b0; rel8 = 1'b0;
    settle();
    check("relw_lv8", lv8, 32'h20);
    check("relw_data8", dout8[5], 32'h0a0a);
    check("relw_full8", full8, 32'h0);

    // Six-lane bank: out-of-range selects are accepted, flagged, dropped.
    sel6 = 3'd1; din6 = 16'h0111; vld6 = 1'b1;
    tick();
    sel6 = 3'd7; din6 = 16'h0fff;
    settle();
    check("oor_rdy6", rdy6, 32'h1);
    tick();
    vld6 = 1'b0;
    settle();
    check("oor_err6", err6, 32'h1);
    check("oor_lv6", lv6, 32'h02);
    tick();
    check("oor_err_clr6", err6, 32'h0);
    sel6 = 3'd6; vld6 = 1'b1;
    tick();
    vld6 = 1'b0;
    settle();
    check("oor6_err6", err6, 32'h1);
    check("oor6_lv6", lv6, 32'h02);

    // Complete the six-lane bank.
    m6 = 6'h02;
    for (int i = 0; i < 6; i++) begin
      if (i != 1) begin
        sel6 = 3'(i); din6 = 16'(16'h0600 + i); vld6 = 1'b1;
        tick();
        m6[i] = 1'b1;
      end
    end
    vld6 = 1'b0;
    settle();
    check("n6_full6", full6, 32'h1);
    check("n6_lv6", lv6, 32'(m6));
    check("n6_data1", dout6[1], 32'h0111);
    check("n6_data5", dout6[5], 32'h0605);
    check("n6_err6", err6, 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
